// File: rtl/updown_pulse_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : updown_pulse_counter                                          |
// | Brief    : Push-button synchroniser + debouncer + rising-edge detector   |
// |            driving a loadable up/down modulo counter with terminal-count |
// |            pulse. Define CNT_SATURATE_EN to saturate at the count        |
// |            limits instead of wrapping.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module updown_pulse_counter #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}},
    parameter int               DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             uphdnl,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             deb_out,
    output logic             step_pulse,
    output logic             tc
);

    // Debounce counter is wide enough to hold DEB_CYCLES-1
    localparam int               c_cnt_w     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_deb_first = c_cnt_w'(1);

    // Debounce FSM encoding
    localparam logic [1:0] c_lo_stable = 2'd0;
    localparam logic [1:0] c_lo_wait   = 2'd1;
    localparam logic [1:0] c_hi_stable = 2'd2;
    localparam logic [1:0] c_hi_wait   = 2'd3;

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_deb_cnt;
    logic               r_deb_out;
    logic               r_deb_prev;
    logic               r_step_pulse;
    logic [WIDTH-1:0]   r_count;
    logic               r_tc;

    logic               w_rise;
    logic [WIDTH-1:0]   w_load_clamped;
    logic [WIDTH-1:0]   w_step_val;
    logic               w_step_tc;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= inc;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: a level change is accepted only after DEB_CYCLES equal samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_lo_stable;
            r_deb_cnt <= '0;
            r_deb_out <= 1'b0;
        end else begin
            case (r_state)
                c_lo_stable: begin
                    if (r_sync2) begin
                        r_state   <= c_lo_wait;
                        r_deb_cnt <= c_deb_first;
                    end
                end
                c_lo_wait: begin
                    if (!r_sync2) begin
                        r_state <= c_lo_stable;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_state   <= c_hi_stable;
                        r_deb_out <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_deb_first;
                    end
                end
                c_hi_stable: begin
                    if (!r_sync2) begin
                        r_state   <= c_hi_wait;
                        r_deb_cnt <= c_deb_first;
                    end
                end
                default: begin // c_hi_wait
                    if (r_sync2) begin
                        r_state <= c_hi_stable;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_state   <= c_lo_stable;
                        r_deb_out <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_deb_first;
                    end
                end
            endcase
        end
    end

    assign w_rise = r_deb_out & ~r_deb_prev;

    // Next count for a step plus its terminal-count flag; limits wrap or saturate
    always_comb begin
        w_step_val = r_count;
        w_step_tc  = 1'b0;
        if (uphdnl) begin
            if (r_count == MAX_VAL) begin
                w_step_tc = 1'b1;
`ifdef CNT_SATURATE_EN
                w_step_val = MAX_VAL;
`else
                w_step_val = '0;
`endif
            end else begin
                w_step_val = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            if (r_count == '0) begin
                w_step_tc = 1'b1;
`ifdef CNT_SATURATE_EN
                w_step_val = '0;
`else
                w_step_val = MAX_VAL;
`endif
            end else begin
                w_step_val = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Out-of-range load values are clamped to the top of the count range
    always_comb begin
        w_load_clamped = load_val;
        if (load_val > MAX_VAL) begin
            w_load_clamped = MAX_VAL;
        end
    end

    // Edge detect and counter update; load overrides a coincident step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_prev   <= 1'b0;
            r_step_pulse <= 1'b0;
            r_count      <= '0;
            r_tc         <= 1'b0;
        end else begin
            r_deb_prev   <= r_deb_out;
            r_step_pulse <= w_rise;
            r_tc         <= 1'b0;
            if (load) begin
                r_count <= w_load_clamped;
            end else if (w_rise) begin
                r_count <= w_step_val;
                r_tc    <= w_step_tc;
            end
        end
    end

    assign count      = r_count;
    assign deb_out    = r_deb_out;
    assign step_pulse = r_step_pulse;
    assign tc         = r_tc;

endmodule
`default_nettype wire
